// File: rtl/adc_frame_packer.sv
// adc_frame_packer: writes one header word, then packs ADC bytes 4-per-word into the RX FIFO.
// Latency: header write appears the cycle after start is sampled; a data word appears the cycle after its 4th sample.
// Backpressure: the ADC stream never stalls; a write launched while fifo_full=1 is dropped and latched in overflow.
module adc_frame_packer #(
  parameter int unsigned NUM_SAMPLES = 1024,
  parameter int unsigned SKIP        = 0,
  parameter logic [15:0] HDR_TAG     = 16'hA55A
) (
  input  logic        clk_32,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  addata,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [31:0] fifo_din,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [15:0] frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_SKIPPING,
    S_CAPTURE,
    S_FLUSH,
    S_DONE
  } state_t;

  // Index of the final sample / final discarded sample. LAST_SKIP is never
  // consulted when SKIP is 0 because SKIPPING is then unreachable.
  localparam logic [15:0] LAST_SMP  = 16'(NUM_SAMPLES - 1);
  localparam logic [7:0]  LAST_SKIP = 8'(SKIP - 1);
  localparam bit          HAS_SKIP  = (SKIP != 0);
  localparam bit          HAS_TAIL  = ((NUM_SAMPLES % 4) != 0);

  state_t      state_q;
  logic        wr_en_q;
  logic [31:0] din_q;
  logic        busy_q;
  logic        done_q;
  logic        ovf_q;
  logic [15:0] frame_cnt_q;
  logic [15:0] frame_cnt_d;
  logic [15:0] smp_cnt_q;
  logic [7:0]  skip_cnt_q;
  logic [23:0] pack_q;     // first three bytes of the word being assembled, MSB first
  logic        frame_inc;

  // A frame is counted only when DONE is left normally; abort in DONE suppresses it.
  always_comb begin
    frame_inc   = (state_q == S_DONE) && !abort;
    frame_cnt_d = frame_cnt_q + {15'd0, frame_inc};
  end

  // Frame sequencer with all outputs registered; abort overrides every state.
  always_ff @(posedge clk_32) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_en_q     <= 1'b0;
      din_q       <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      frame_cnt_q <= 16'd0;
      smp_cnt_q   <= 16'd0;
      skip_cnt_q  <= 8'd0;
      pack_q      <= 24'd0;
    end else begin
      wr_en_q     <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= frame_cnt_d;
      if (abort && (state_q != S_IDLE)) begin
        // Partial word and counters are thrown away; no done, no count.
        state_q    <= S_IDLE;
        busy_q     <= 1'b0;
        smp_cnt_q  <= 16'd0;
        skip_cnt_q <= 8'd0;
        pack_q     <= 24'd0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && !abort) begin
              state_q    <= S_HEADER;
              busy_q     <= 1'b1;
              smp_cnt_q  <= 16'd0;
              skip_cnt_q <= 8'd0;
              pack_q     <= 24'd0;
              // Header write is launched here so it is on the bus during HEADER.
              if (fifo_full) begin
                ovf_q <= 1'b1;
              end else begin
                ovf_q   <= 1'b0;
                wr_en_q <= 1'b1;
                din_q   <= {HDR_TAG, frame_cnt_q};
              end
            end
          end
          S_HEADER: begin
            state_q <= HAS_SKIP ? S_SKIPPING : S_CAPTURE;
          end
          S_SKIPPING: begin
            skip_cnt_q <= skip_cnt_q + 8'd1;
            if (skip_cnt_q == LAST_SKIP) begin
              state_q <= S_CAPTURE;
            end
          end
          S_CAPTURE: begin
            smp_cnt_q <= smp_cnt_q + 16'd1;
            case (smp_cnt_q[1:0])
              2'd0: pack_q[23:16] <= addata;
              2'd1: pack_q[15:8]  <= addata;
              2'd2: pack_q[7:0]   <= addata;
              default: begin
                // Fourth byte completes the word; clear the assembly register
                // so a trailing partial word starts from zeros.
                pack_q <= 24'd0;
                if (fifo_full) begin
                  ovf_q <= 1'b1;
                end else begin
                  wr_en_q <= 1'b1;
                  din_q   <= {pack_q, addata};
                end
              end
            endcase
            if (smp_cnt_q == LAST_SMP) begin
              state_q <= HAS_TAIL ? S_FLUSH : S_DONE;
            end
          end
          S_FLUSH: begin
            state_q <= S_DONE;
            pack_q  <= 24'd0;
            if (fifo_full) begin
              ovf_q <= 1'b1;
            end else begin
              wr_en_q <= 1'b1;
              din_q   <= {pack_q, 8'h00};
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign fifo_wr_en = wr_en_q;
  assign fifo_din   = din_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
